// File: rtl/cbus_arbiter.sv
// Cache-bus arbiter: shares one bridge port among NUM_INPUTS requesters, holding the grant until ready && last.
// Define CBUS_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).

package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [7:0]  len;
        logic [3:0]  strobe;
        logic [31:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_INPUTS = 2
) (
    input  logic       aclk,
    input  logic       areset,
    input  cbus_req_t  ireqs  [NUM_INPUTS],
    output cbus_resp_t iresps [NUM_INPUTS],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    localparam int SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] sel_next;
    logic [SEL_W-1:0] winner;
    logic             any_valid;

`ifdef CBUS_ARB_ROUND_ROBIN_EN
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_next;
    int               scan_idx;

    // Scan from the highest offset down so the valid index closest to rr_ptr is the last one written.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        scan_idx  = 0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_INPUTS;
            if (ireqs[scan_idx].valid) begin
                any_valid = 1'b1;
                winner    = SEL_W'(scan_idx);
            end
        end
    end
`else
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (ireqs[i].valid) begin
                any_valid = 1'b1;
                winner    = SEL_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            state <= state_next;
            sel   <= sel_next;
        end
    end

`ifdef CBUS_ARB_ROUND_ROBIN_EN
    always_ff @(posedge aclk) begin
        if (areset) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_next;
        end
    end
`endif

    // Outputs stay zero in IDLE and during reset; BUSY is a pure combinational pass-through of the granted port.
    always_comb begin
        state_next = state;
        sel_next   = sel;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
        rr_next    = rr_ptr;
`endif
        oreq       = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            iresps[i] = '0;
        end

        case (state)
            IDLE: begin
                if (any_valid) begin
                    sel_next   = winner;
                    state_next = BUSY;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
                    rr_next    = (winner == SEL_W'(NUM_INPUTS - 1)) ? '0 : winner + 1'b1;
`endif
                end
            end
            BUSY: begin
                if (!areset) begin
                    oreq = ireqs[sel];
                    for (int i = 0; i < NUM_INPUTS; i++) begin
                        if (SEL_W'(i) == sel) begin
                            iresps[i] = oresp;
                        end
                    end
                end
                if (oresp.ready && oresp.last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Scoreboard bench for cbus_arbiter: each driven cycle pushes its expected outputs, the negedge monitor pops and compares.
// Expectations follow the default fixed-priority build unless CBUS_ARB_ROUND_ROBIN_EN is defined.

module tb_cbus_arbiter;
    import cbus_pkg::*;

    logic       aclk = 1'b0;
    logic       areset;
    cbus_req_t  ireqs  [2];
    cbus_resp_t iresps [2];
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    typedef struct {
        string      tag;
        cbus_req_t  oreq;
        cbus_resp_t r0;
        cbus_resp_t r1;
        bit         chk_sel;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    int         n_compared   = 0;
    int         n_mismatched = 0;
    cbus_req_t  noreq  = '0;
    cbus_resp_t norsp  = '0;

    cbus_arbiter #(.NUM_INPUTS(2)) dut (
        .aclk   (aclk),
        .areset (areset),
        .ireqs  (ireqs),
        .iresps (iresps),
        .oreq   (oreq),
        .oresp  (oresp)
    );

    always #5 aclk = ~aclk;

    function automatic cbus_req_t mkReq(logic v, logic w, logic [31:0] addr, logic [7:0] len, logic [31:0] data);
        cbus_req_t r;
        r.valid    = v;
        r.is_write = w;
        r.addr     = addr;
        r.size     = 2'd2;
        r.len      = len;
        r.strobe   = w ? 4'hf : 4'h0;
        r.data     = data;
        return r;
    endfunction

    function automatic cbus_resp_t mkResp(logic ready, logic last, logic [31:0] data);
        cbus_resp_t r;
        r.ready = ready;
        r.last  = last;
        r.data  = data;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of stimulus and queue what the outputs must look like in that same cycle.
    task automatic applyStimulus(input string tag, input cbus_req_t q0, input cbus_req_t q1, input cbus_resp_t rsp,
                                 input logic rst, input cbus_req_t e_oreq, input cbus_resp_t e0, input cbus_resp_t e1,
                                 input bit chk_sel);
        exp_t e;
        ireqs[0] = q0;
        ireqs[1] = q1;
        oresp    = rsp;
        areset   = rst;
        e.tag     = tag;
        e.oreq    = e_oreq;
        e.r0      = e0;
        e.r1      = e1;
        e.chk_sel = chk_sel;
        sb.push_back(e);
        @(posedge aclk);
        #1;
    endtask

    always @(negedge aclk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            checkOutput({cur.tag, "/oreq"}, 128'(oreq), 128'(cur.oreq));
            checkOutput({cur.tag, "/resp0"}, 128'(iresps[0]), 128'(cur.r0));
            checkOutput({cur.tag, "/resp1"}, 128'(iresps[1]), 128'(cur.r1));
            if (cur.chk_sel) begin
                checkOutput({cur.tag, "/sel"}, 128'(dut.sel), 128'(0));
`ifdef CBUS_ARB_ROUND_ROBIN_EN
                checkOutput({cur.tag, "/rr_ptr"}, 128'(dut.rr_ptr), 128'(0));
`endif
            end
        end
    end

    task automatic applyReset(input string tag);
        cbus_req_t busy_req;
        busy_req = mkReq(1'b1, 1'b0, 32'hdead_0000, 8'd3, 32'h0);
        applyStimulus(tag, busy_req, busy_req, mkResp(1'b1, 1'b1, 32'h5555), 1'b1, noreq, norsp, norsp, 1'b0);
        applyStimulus(tag, busy_req, busy_req, mkResp(1'b1, 1'b1, 32'h5555), 1'b1, noreq, norsp, norsp, 1'b0);
    endtask

    initial begin
        cbus_req_t  r0;
        cbus_req_t  r1;
        cbus_req_t  w0;
        cbus_resp_t rsp;
        int         g;

        ireqs[0] = '0;
        ireqs[1] = '0;
        oresp    = '0;
        areset   = 1'b1;
        @(posedge aclk);
        #1;

        // Single read on port 1, one stall cycle, then four beats with last on the fourth.
        applyReset("rst1");
        r1 = mkReq(1'b1, 1'b0, 32'h0000_1000, 8'd3, 32'h0);
        applyStimulus("t1_idle", noreq, r1, norsp, 1'b0, noreq, norsp, norsp, 1'b0);
        applyStimulus("t1_stall", noreq, r1, norsp, 1'b0, r1, norsp, norsp, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rsp = mkResp(1'b1, (i == 3), 32'hA0 + 32'(i));
            applyStimulus("t1_beat", noreq, r1, rsp, 1'b0, r1, norsp, rsp, 1'b0);
        end
        applyStimulus("t1_done", noreq, noreq, norsp, 1'b0, noreq, norsp, norsp, 1'b0);

        // Both valid together: port 0 first, port 1 after one IDLE cycle.
        applyReset("rst2");
        r0  = mkReq(1'b1, 1'b0, 32'h0000_2000, 8'd0, 32'h0);
        r1  = mkReq(1'b1, 1'b0, 32'h0000_3000, 8'd0, 32'h0);
        rsp = mkResp(1'b1, 1'b1, 32'h1234_5678);
        applyStimulus("t2_idle", r0, r1, norsp, 1'b0, noreq, norsp, norsp, 1'b0);
        applyStimulus("t2_g0", r0, r1, rsp, 1'b0, r0, rsp, norsp, 1'b0);
        applyStimulus("t2_gap", noreq, r1, norsp, 1'b0, noreq, norsp, norsp, 1'b0);
        applyStimulus("t2_g1", noreq, r1, rsp, 1'b0, r1, norsp, rsp, 1'b0);
        applyStimulus("t2_end", noreq, noreq, norsp, 1'b0, noreq, norsp, norsp, 1'b0);

        // Both held valid across four single-beat bursts.
        applyReset("rst2b");
        applyStimulus("t2b_idle", r0, r1, norsp, 1'b0, noreq, norsp, norsp, 1'b0);
        for (int k = 0; k < 4; k++) begin
`ifdef CBUS_ARB_ROUND_ROBIN_EN
            g = k % 2;
`else
            g = 0;
`endif
            if (g == 0) begin
                applyStimulus("t2b_g0", r0, r1, rsp, 1'b0, r0, rsp, norsp, 1'b0);
            end else begin
                applyStimulus("t2b_g1", r0, r1, rsp, 1'b0, r1, norsp, rsp, 1'b0);
            end
            applyStimulus("t2b_gap", r0, r1, norsp, 1'b0, noreq, norsp, norsp, 1'b0);
        end

        // Write burst on port 0 with data changing per beat; port 1 arrives mid-burst and waits.
        applyReset("rst3");
        w0 = mkReq(1'b1, 1'b1, 32'h0000_4000, 8'd1, 32'hCAFE_0000);
        r1 = mkReq(1'b1, 1'b0, 32'h0000_5000, 8'd0, 32'h0);
        applyStimulus("t3_idle", w0, noreq, norsp, 1'b0, noreq, norsp, norsp, 1'b0);
        rsp = mkResp(1'b1, 1'b0, 32'h0);
        applyStimulus("t3_beat0", w0, r1, rsp, 1'b0, w0, rsp, norsp, 1'b0);
        w0.data = 32'hCAFE_0001;
        rsp = mkResp(1'b1, 1'b1, 32'h0);
        applyStimulus("t3_beat1", w0, r1, rsp, 1'b0, w0, rsp, norsp, 1'b0);
        applyStimulus("t3_gap", noreq, r1, norsp, 1'b0, noreq, norsp, norsp, 1'b0);
        rsp = mkResp(1'b1, 1'b1, 32'h7777);
        applyStimulus("t3_g1", noreq, r1, rsp, 1'b0, r1, norsp, rsp, 1'b0);
        applyStimulus("t3_end", noreq, noreq, norsp, 1'b0, noreq, norsp, norsp, 1'b0);

        // Single-beat read with a new request on the last beat, then a requester dropping valid mid-burst.
        applyReset("rst4");
        r0 = mkReq(1'b1, 1'b0, 32'h0000_6000, 8'd0, 32'h0);
        r1 = mkReq(1'b1, 1'b0, 32'h0000_7000, 8'd1, 32'h0);
        rsp = mkResp(1'b1, 1'b1, 32'h6666);
        applyStimulus("t4_idle", r0, noreq, norsp, 1'b0, noreq, norsp, norsp, 1'b0);
        applyStimulus("t4_last", r0, r1, rsp, 1'b0, r0, rsp, norsp, 1'b0);
        applyStimulus("t4_nodup", noreq, r1, norsp, 1'b0, noreq, norsp, norsp, 1'b0);
        applyStimulus("t4_g1wait", noreq, r1, norsp, 1'b0, r1, norsp, norsp, 1'b0);
        r1.valid = 1'b0;
        applyStimulus("t4_drop", noreq, r1, rsp, 1'b0, r1, norsp, rsp, 1'b0);
        applyStimulus("t4_end", noreq, noreq, norsp, 1'b0, noreq, norsp, norsp, 1'b0);

        // Reset in the second beat of a four-beat burst, then a fresh grant.
        applyReset("rst5");
        r1 = mkReq(1'b1, 1'b0, 32'h0000_8000, 8'd3, 32'h0);
        r0 = mkReq(1'b1, 1'b0, 32'h0000_9000, 8'd0, 32'h0);
        applyStimulus("t5_idle", noreq, r1, norsp, 1'b0, noreq, norsp, norsp, 1'b0);
        rsp = mkResp(1'b1, 1'b0, 32'hB0);
        applyStimulus("t5_beat1", noreq, r1, rsp, 1'b0, r1, norsp, rsp, 1'b0);
        rsp = mkResp(1'b1, 1'b0, 32'hB1);
        applyStimulus("t5_rst", noreq, r1, rsp, 1'b1, noreq, norsp, norsp, 1'b0);
        applyStimulus("t5_after", r0, noreq, norsp, 1'b0, noreq, norsp, norsp, 1'b1);
        rsp = mkResp(1'b1, 1'b1, 32'hC0);
        applyStimulus("t5_g0", r0, noreq, rsp, 1'b0, r0, rsp, norsp, 1'b0);
        applyStimulus("t5_end", noreq, noreq, norsp, 1'b0, noreq, norsp, norsp, 1'b0);

        @(negedge aclk);
        #1;
        checkOutput("drain", 128'(sb.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
